// File: rtl/windowed_regfile_le_sclr.sv
// windowed_regfile_le_sclr: SPARC windowed register file (8 globals + NWINDOWS x 16) with CWP and SAVE/RESTORE traps
module windowed_regfile_le_sclr #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter int CWPW     = 5
) (
  input  logic                clk_i,
  input  logic                clr_n_i,
  input  logic [4:0]          ra_i,
  input  logic [4:0]          rb_i,
  output logic [WIDTH-1:0]    ya_o,
  output logic [WIDTH-1:0]    yb_o,
  input  logic [4:0]          rw_i,
  input  logic [WIDTH-1:0]    dw_i,
  input  logic                load_n_i,
  input  logic                save_n_i,
  input  logic                restore_n_i,
  input  logic [NWINDOWS-1:0] wim_i,
  output logic [CWPW-1:0]     cwp_o,
  output logic                wovf_o,
  output logic                wunf_o
);
  localparam int NREG = 8 + 16 * NWINDOWS;
  localparam int PW   = $clog2(NREG);
  localparam int WX   = 2 ** CWPW;
  localparam logic [CWPW-1:0] LAST = CWPW'(NWINDOWS - 1);
  logic [WIDTH-1:0] regs_q [NREG];
  logic [CWPW-1:0]  cwp_q, cwp_d, dn, up;
  logic [WX-1:0]    wim_x;
  logic             wovf_q, wunf_q, wovf_d, wunf_d, sv, rs, we;
  logic [PW-1:0]    pw;
  // ins of window w alias the outs of window w+1, so r24..r31 map 16 below r8..r15 of the next window
  function automatic logic [PW-1:0] phys(input logic [4:0] r, input logic [CWPW-1:0] w);
    logic [CWPW-1:0] wn;
    wn = (w == LAST) ? '0 : w + 1'b1;
    return (r < 5'd8) ? PW'(r) : (r < 5'd24) ? PW'(16 * int'(w) + int'(r)) : PW'(16 * int'(wn) + int'(r) - 16);
  endfunction
  always_comb begin
    wim_x  = WX'(wim_i);
    sv     = ~save_n_i & restore_n_i;
    rs     = save_n_i & ~restore_n_i;
    dn     = (cwp_q == '0) ? LAST : cwp_q - 1'b1;
    up     = (cwp_q == LAST) ? '0 : cwp_q + 1'b1;
    wovf_d = sv & wim_x[dn];
    wunf_d = rs & wim_x[up];
    cwp_d  = (sv & ~wovf_d) ? dn : (rs & ~wunf_d) ? up : cwp_q;
    we     = ~load_n_i & (rw_i != '0) & ~wovf_d & ~wunf_d;
    pw     = phys(rw_i, cwp_d);
  end
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      cwp_q  <= '0;
      wovf_q <= 1'b0;
      wunf_q <= 1'b0;
    end else begin
      if (we) regs_q[pw] <= dw_i;
      cwp_q  <= cwp_d;
      wovf_q <= wovf_d;
      wunf_q <= wunf_d;
    end
  end
  assign ya_o   = (ra_i == '0) ? '0 : regs_q[phys(ra_i, cwp_q)];
  assign yb_o   = (rb_i == '0) ? '0 : regs_q[phys(rb_i, cwp_q)];
  assign cwp_o  = cwp_q;
  assign wovf_o = wovf_q;
  assign wunf_o = wunf_q;
endmodule
